// File: rtl/ldl_p2ram_pipe_v2.sv
// Simple dual-port RAM with one write port and one read port on a single clock.
// It supports byte-enable writes, a read latency of 1..4 cycles, a selectable
// same-address collision policy, and a hardware clear of the array after reset.
module ldl_p2ram_pipe_v2 #(
  parameter int unsigned    DW    = 32,
  parameter int unsigned    BW    = 8,
  parameter int unsigned    NB    = DW / BW,
  parameter int unsigned    DEPTH = 16,
  parameter int unsigned    AW    = $clog2(DEPTH),
  parameter int unsigned    RL    = 1,
  parameter int unsigned    WMODE = 0,
  parameter bit             CLR   = 1'b1,
  parameter logic [DW-1:0]  INIT  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [NB-1:0] wbe,
  input  logic [DW-1:0] din,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] dout,
  output logic          rv,
  output logic          coll,
  output logic          aerr,
  output logic          busy
);

  if ((DW % BW) != 0) begin : g_chk_dw
    $error("ldl_p2ram_pipe_v2: DW must be a multiple of BW");
  end
  if (RL < 1 || RL > 4) begin : g_chk_rl
    $error("ldl_p2ram_pipe_v2: RL must be in 1..4");
  end
  if (WMODE > 2) begin : g_chk_wmode
    $error("ldl_p2ram_pipe_v2: WMODE must be 0, 1 or 2");
  end

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam bit            BYPASS    = (WMODE == 1);
  localparam bit            FLAG_COLL = (WMODE == 2);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  logic [DW-1:0] mem [DEPTH];

  logic          wa_in, ra_in, wr_ok, rd_ok, hit;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] pd [RL];
  logic [RL-1:0] pv, pc, pa;

  assign busy  = (state == S_CLEAR);
  assign wa_in = ({1'b0, wa} < DEPTH_W);
  assign ra_in = ({1'b0, ra} < DEPTH_W);
  assign wr_ok = !busy && we && wa_in && (|wbe);
  assign rd_ok = !busy && re;
  assign hit   = wr_ok && rd_ok && ra_in && (wa == ra);

  // Clear FSM state register; reset always restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR ? S_CLEAR : S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Clear FSM next state: walk the pointer across the array, then leave to IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST) begin
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  // Array write port: the clear sweep takes priority, otherwise a byte-masked write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[ptr] <= INIT;
      end else if (wr_ok) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wbe[i]) mem[wa][i*BW +: BW] <= din[i*BW +: BW];
        end
      end
    end
  end

  // Read word at the issue cycle. Write-first mode merges enabled lanes of din.
  always_comb begin
    rd_word = '0;
    if (ra_in) begin
      rd_word = mem[ra];
      if (BYPASS && hit) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wbe[i]) rd_word[i*BW +: BW] = din[i*BW +: BW];
        end
      end
    end
  end

  // Read pipeline: stage 0 captures the array read, later stages shift forward.
  // Data stages load only on a valid entry so dout holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pc <= '0;
      pa <= '0;
      for (int unsigned i = 0; i < RL; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_ok;
      pc[0] <= FLAG_COLL && hit;
      pa[0] <= rd_ok && !ra_in;
      if (rd_ok) pd[0] <= rd_word;
      for (int unsigned i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pc[i] <= pc[i-1];
        pa[i] <= pa[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign dout = pd[RL-1];
  assign rv   = pv[RL-1];
  assign coll = pc[RL-1];
  assign aerr = pa[RL-1];

`ifndef SYNTHESIS
  // Simulation notices for flagged collisions and out-of-range addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (FLAG_COLL && hit)
        $display("ldl_p2ram_pipe_v2: read/write collision at address %0d", ra);
      if (!busy && we && !wa_in)
        $display("ldl_p2ram_pipe_v2: write address %0d out of range, dropped", wa);
      if (rd_ok && !ra_in)
        $display("ldl_p2ram_pipe_v2: read address %0d out of range", ra);
    end
  end
`endif

endmodule

// File: tb/tb_ldl_p2ram_pipe_v2.sv
// Directed bench for ldl_p2ram_pipe_v2. Three instances share all inputs:
// u0 RL=1 read-first, u1 RL=3 write-first, u2 RL=2 flag-only; DEPTH=10.
module tb_ldl_p2ram_pipe_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [3:0]  wa  = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] din = '0;
  logic        re  = 1'b0;
  logic [3:0]  ra  = '0;

  logic [31:0] o_d [3];
  logic [2:0]  o_v, o_c, o_a, o_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_mem [10];
  logic [31:0] r_d [3];
  logic [2:0]  r_v, r_c, r_a;

  always #5 clk = ~clk;

  ldl_p2ram_pipe_v2 #(.DEPTH(10), .RL(1), .WMODE(0), .INIT(32'hA5A5A5A5)) u0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wbe(wbe), .din(din), .re(re), .ra(ra),
    .dout(o_d[0]), .rv(o_v[0]), .coll(o_c[0]), .aerr(o_a[0]), .busy(o_b[0]));

  ldl_p2ram_pipe_v2 #(.DEPTH(10), .RL(3), .WMODE(1), .INIT(32'hA5A5A5A5)) u1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wbe(wbe), .din(din), .re(re), .ra(ra),
    .dout(o_d[1]), .rv(o_v[1]), .coll(o_c[1]), .aerr(o_a[1]), .busy(o_b[1]));

  ldl_p2ram_pipe_v2 #(.DEPTH(10), .RL(2), .WMODE(2), .INIT(32'hA5A5A5A5)) u2 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wbe(wbe), .din(din), .re(re), .ra(ra),
    .dout(o_d[2]), .rv(o_v[2]), .coll(o_c[2]), .aerr(o_a[2]), .busy(o_b[2]));

  // Single-cycle write; called just after a negedge, returns at the next negedge.
  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    we = 1'b1; wa = a; wbe = be; din = d;
    if (a < 4'd10)
      for (int l = 0; l < 4; l++) if (be[l]) exp_mem[a][8*l +: 8] = d[8*l +: 8];
    @(negedge clk);
    we = 1'b0; wbe = '0;
  endtask

  // One read (optionally with a simultaneous write); captures each instance at its latency.
  task automatic issue(input logic [3:0] a, input logic w, input logic [3:0] wadr,
                       input logic [3:0] be, input logic [31:0] d);
    we = w; wa = wadr; wbe = be; din = d; re = 1'b1; ra = a;
    if (w && wadr < 4'd10)
      for (int l = 0; l < 4; l++) if (be[l]) exp_mem[wadr][8*l +: 8] = d[8*l +: 8];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin we = 1'b0; re = 1'b0; wbe = '0; end
      if (k == 1) begin r_d[0] = o_d[0]; r_v[0] = o_v[0]; r_c[0] = o_c[0]; r_a[0] = o_a[0]; end
      if (k == 2) begin r_d[2] = o_d[2]; r_v[2] = o_v[2]; r_c[2] = o_c[2]; r_a[2] = o_a[2]; end
      if (k == 3) begin r_d[1] = o_d[1]; r_v[1] = o_v[1]; r_c[1] = o_c[1]; r_a[1] = o_a[1]; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_v[i] !== 1'b0 || o_c[i] !== 1'b0 || o_a[i] !== 1'b0 || o_d[i] !== 32'h0 ||
          o_b[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset inst%0d: rv=%b coll=%b aerr=%b dout=%h busy=%b want 0 0 0 0 1",
                 i, o_v[i], o_c[i], o_a[i], o_d[i], o_b[i]);
      end
    end
  endtask

  task automatic test_clear;
    int cnt [3];
    cnt = '{0, 0, 0};
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (o_b == 3'b000) break;
      for (int i = 0; i < 3; i++) if (o_b[i]) cnt[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cnt[i] !== 10) begin
        bad++;
        $display("FAIL clear_busy_len inst%0d: got %0d want 10", i, cnt[i]);
      end
    end
    for (int a = 0; a < 10; a++) begin
      issue(4'(a), 1'b0, 4'd0, 4'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (r_v[i] !== 1'b1 || r_d[i] !== 32'hA5A5A5A5) begin
          bad++;
          $display("FAIL clear_read inst%0d addr%0d: rv=%b dout=%h want 1 a5a5a5a5",
                   i, a, r_v[i], r_d[i]);
        end
      end
    end
  endtask

  task automatic test_byte_enable;
    wr(4'd3, 4'hF, 32'h11223344);
    wr(4'd3, 4'b0101, 32'hAABBCCDD);
    issue(4'd3, 1'b0, 4'd0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_v[i] !== 1'b1 || r_d[i] !== 32'h11BB33DD) begin
        bad++;
        $display("FAIL byte_enable inst%0d: rv=%b dout=%h want 1 11bb33dd", i, r_v[i], r_d[i]);
      end
    end
    wr(4'd3, 4'h0, 32'hFFFFFFFF);
    issue(4'd3, 1'b0, 4'd0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_d[i] !== 32'h11BB33DD) begin
        bad++;
        $display("FAIL wbe_zero_noop inst%0d: dout=%h want 11bb33dd", i, r_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < 5; a++) wr(4'(a), 4'hF, 32'(a));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        total++;
        if (o_v[1] !== ((k >= 3 && k <= 7) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL rl3_rv k=%0d: got %b want %b", k, o_v[1], (k >= 3 && k <= 7));
        end
        if (k >= 3) begin
          total++;
          if (o_d[1] !== ((k <= 7) ? 32'(k - 3) : 32'd4)) begin
            bad++;
            $display("FAIL rl3_dout k=%0d: got %h want %h", k, o_d[1],
                     (k <= 7) ? 32'(k - 3) : 32'd4);
          end
        end
        total++;
        if (o_v[0] !== ((k <= 5) ? 1'b1 : 1'b0) || (k <= 5 && o_d[0] !== 32'(k - 1))) begin
          bad++;
          $display("FAIL rl1_stream k=%0d: rv=%b dout=%h want rv=%b dout=%h", k, o_v[0],
                   o_d[0], (k <= 5), 32'(k - 1));
        end
      end
      if (k < 5) begin re = 1'b1; ra = 4'(k); end
      else re = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_collision;
    logic [31:0] want [3];
    want = '{32'h0, 32'h0000FFFF, 32'h0};
    wr(4'd5, 4'hF, 32'h0);
    issue(4'd5, 1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_v[i] !== 1'b1 || r_d[i] !== want[i] || r_c[i] !== (i == 2)) begin
        bad++;
        $display("FAIL collision inst%0d: rv=%b dout=%h coll=%b want 1 %h %b",
                 i, r_v[i], r_d[i], r_c[i], want[i], (i == 2));
      end
    end
    issue(4'd5, 1'b0, 4'd0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_d[i] !== 32'h0000FFFF || r_c[i] !== 1'b0) begin
        bad++;
        $display("FAIL collision_after inst%0d: dout=%h coll=%b want 0000ffff 0",
                 i, r_d[i], r_c[i]);
      end
    end
    wr(4'd7, 4'hF, 32'h12345678);
    issue(4'd7, 1'b0, 4'd0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_d[i] !== 32'h12345678) begin
        bad++;
        $display("FAIL write_then_read inst%0d: dout=%h want 12345678", i, r_d[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    issue(4'd12, 1'b1, 4'd12, 4'hF, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_v[i] !== 1'b1 || r_d[i] !== 32'h0 || r_a[i] !== 1'b1 || r_c[i] !== 1'b0) begin
        bad++;
        $display("FAIL oor_read inst%0d: rv=%b dout=%h aerr=%b coll=%b want 1 0 1 0",
                 i, r_v[i], r_d[i], r_a[i], r_c[i]);
      end
    end
    for (int a = 0; a < 10; a++) begin
      issue(4'(a), 1'b0, 4'd0, 4'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (r_d[i] !== exp_mem[a] || r_a[i] !== 1'b0) begin
          bad++;
          $display("FAIL oor_contents inst%0d addr%0d: dout=%h aerr=%b want %h 0",
                   i, a, r_d[i], r_a[i], exp_mem[a]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt [3];
    cnt = '{0, 0, 0};
    re = 1'b1; ra = 4'd1;
    @(negedge clk);
    re = 1'b0;
    total++;
    if (o_v[0] !== 1'b1 || o_d[0] !== exp_mem[1]) begin
      bad++;
      $display("FAIL mid_inflight u0: rv=%b dout=%h want 1 %h", o_v[0], o_d[0], exp_mem[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (o_v !== 3'b000 || o_b !== 3'b111 || o_d[0] !== 32'h0 || o_d[1] !== 32'h0 ||
        o_d[2] !== 32'h0) begin
      bad++;
      $display("FAIL mid_flush: rv=%b busy=%b dout0=%h dout1=%h dout2=%h want 000 111 0 0 0",
               o_v, o_b, o_d[0], o_d[1], o_d[2]);
    end
    rst = 1'b0;
    // Clear pointer reaches 4 at the fourth negedge after release.
    repeat (4) @(negedge clk);
    total++;
    if (o_b !== 3'b111) begin
      bad++;
      $display("FAIL mid_busy_ptr4: busy=%b want 111", o_b);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    re = 1'b1; ra = 4'd0;
    for (int n = 0; n < 40; n++) begin
      if (o_b == 3'b000) break;
      for (int i = 0; i < 3; i++) if (o_b[i]) cnt[i]++;
      total++;
      if (o_v !== 3'b000) begin
        bad++;
        $display("FAIL busy_ignores_re n=%0d: rv=%b want 000", n, o_v);
      end
      @(negedge clk);
    end
    re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cnt[i] !== 10) begin
        bad++;
        $display("FAIL mid_busy_len inst%0d: got %0d want 10", i, cnt[i]);
      end
    end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (o_v !== 3'b000) begin
        bad++;
        $display("FAIL post_clear_no_rv: rv=%b want 000", o_v);
      end
    end
    for (int a = 0; a < 10; a++) exp_mem[a] = 32'hA5A5A5A5;
    for (int a = 0; a < 10; a += 9) begin
      issue(4'(a), 1'b0, 4'd0, 4'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (r_v[i] !== 1'b1 || r_d[i] !== 32'hA5A5A5A5) begin
          bad++;
          $display("FAIL mid_recleared inst%0d addr%0d: rv=%b dout=%h want 1 a5a5a5a5",
                   i, a, r_v[i], r_d[i]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 10; a++) exp_mem[a] = 32'hA5A5A5A5;
    test_reset;
    test_clear;
    test_byte_enable;
    test_back_to_back;
    test_collision;
    test_out_of_range;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ldl_p2ram_pipe_v2.md
Name: ldl_p2ram_pipe_v2

Overview:
Parametrised simple dual-port RAM (one write port, one read port, one clock), successor to the v1 registered-read RAM. Adds byte-enable writes, configurable read latency, a selectable same-address collision policy, and post-reset hardware clear of the array. Used as the storage core for FIFOs, descriptor tables and line buffers where deterministic latency and a known initial state are required.

Parameters:
DW, 32, data width in bits; must be a multiple of BW
BW, 8, byte-enable granularity in bits
NB, DW/BW, number of byte lanes (derived)
DEPTH, 16, number of words; need not be a power of 2
AW, $clog2(DEPTH), address width (derived)
RL, 1, read latency in cycles from re to rv/dout, legal 1..4
WMODE, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data bypassed), 2 = flag-only (old data, rv still 1, coll flagged)
CLR, 1, 1 = clear the array after reset; 0 = no clear, busy never asserts
INIT, '0, DW-bit value written to every word during clear

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
we  in  1  write enable
wa  in  AW  write address
wbe  in  NB  byte enables; lane i covers din[i*BW +: BW]
din  in  DW  write data
re  in  1  read enable
ra  in  AW  read address
dout  out  DW  read data, valid when rv=1
rv  out  1  read valid, RL cycles after an accepted re
coll  out  1  same-address collision on the read returned in this cycle, aligned with rv
aerr  out  1  the read returned in this cycle had ra >= DEPTH, aligned with rv
busy  out  1  clear in progress; we/re ignored while high

Behaviour:
- Reset (rst=1 at posedge): rv=0, coll=0, aerr=0, dout=0, read pipeline flushed. busy=1 if CLR=1, else 0. Array contents untouched by reset itself.
- Clear FSM (CLR=1), states IDLE, CLEAR:
  - rst forces CLEAR with ptr=0.
  - In CLEAR, write INIT to mem[ptr] each cycle, ptr++; on ptr==DEPTH-1, go to IDLE the following cycle, busy drops with it.
  - busy is high exactly DEPTH cycles after reset deassertion.
  - rst during CLEAR restarts at ptr=0.
  - while busy: we, re ignored, no rv issued.
- Write (busy=0, we=1, wa<DEPTH): for each lane i with wbe[i]=1, mem[wa] lane i <= din lane i; other lanes unchanged. we with wbe=0 is a no-op. wa>=DEPTH: write dropped, no other effect.
- Read (busy=0, re=1): array sampled at the re cycle. Result appears on dout with rv=1 exactly RL cycles later; pipeline stages RL-1 after the array register. Fully pipelined: one read per cycle, back-to-back re gives back-to-back rv. rv=0 cycles hold the previous dout.
- ra>=DEPTH: rv=1, dout=0, aerr=1, coll=0.
- Collision (same cycle we=1, re=1, wa==ra<DEPTH, wbe!=0):
  - WMODE 0: dout = old word, coll=0.
  - WMODE 1: dout = old word with enabled lanes replaced by din, coll=0.
  - WMODE 2: dout = old word, coll=1.
  - Write always completes in all modes.
- A write at cycle t is visible to a read issued at t+1 in all modes.
- coll and aerr are 0 whenever rv=0.
- Simulation only: $display on collision when WMODE=2 and on ra/wa>=DEPTH.
- Parameter checks (elaboration error): DW%BW!=0, RL outside 1..4, WMODE>2.

Test Plan:
- Clear: DW=32, DEPTH=10, INIT=32'hA5A5A5A5, pulse rst 1 cycle -> busy high exactly 10 cycles; then reads of addr 0..9 return A5A5A5A5 with rv=1.
- Byte enable: write 0x11223344 to addr 3 with wbe=4'hF, then 0xAABBCCDD with wbe=4'b0101 -> read addr 3 returns 0x11BB33DD.
- Latency/throughput: RL=3, re on 5 consecutive cycles to addr 0..4 holding 0..4 -> rv high exactly cycles t+3..t+7, dout 0,1,2,3,4 in order.
- Collision: mem[5]=0x00000000; same cycle we=1, wa=ra=5, wbe=4'b0011, din=0xFFFFFFFF, re=1 -> WMODE0: dout=0, coll=0; WMODE1: dout=0x0000FFFF, coll=0; WMODE2: dout=0, coll=1; next read of 5 returns 0x0000FFFF in all modes.
- Out of range: DEPTH=10, we to wa=12, re ra=12 -> rv=1, dout=0, aerr=1; mem contents 0..9 unchanged.
- Reset mid-operation: rst asserted at clear ptr=4 and with reads in flight (RL=2) -> rv=0 next cycle, in-flight reads discarded, busy high for a full DEPTH cycles after release.
